// File: rtl/mix_columns_iter.sv
// -----------------------------------------------------------------------------
// mix_columns_iter
//
// Iterative AES MixColumns engine (forward direction, encryption datapath).
// One 128-bit state is accepted per handshake and one 32-bit column is
// transformed per clock, so a single column multiplier covers the whole state.
// The finished state is held until downstream accepts it. When in_final is set
// at the accept edge, the state bypasses MixColumns (last AES round).
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. A source holds valid and data stable until the
// transfer. in_ready does not depend on in_valid, and out_valid does not
// depend on out_ready. Only one state is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   in_data/in_final valid
//   in_ready   engine can accept a state (IDLE and not in reset)
//   in_data    state; column 0 = [127:96], column 3 = [31:0];
//              byte 0 of each column is its MSB byte
//   in_final   final round: bypass MixColumns (sampled at accept only)
//   out_valid  out_data holds a finished state
//   out_ready  downstream accepts out_data
//   out_data   transformed (or bypassed) state, wired from the working register
//   busy       high in any state other than IDLE
// -----------------------------------------------------------------------------
module mix_columns_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_final,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     col_q, col_d;
  logic [127:0]   st_q, st_d;

  // Bit offset of the current column: column 0 sits at bit 96, column 3 at
  // bit 0, i.e. (3 - col) * 32, which is {~col, 5'b0}.
  logic [6:0]     col_lsb;
  logic [31:0]    col_word;

  // GF(2^8) multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns on one column; byte 0 is the MSB byte.
  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] x0, x1, x2, x3;
    logic [7:0] m0, m1, m2, m3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    x0 = xtime(b0);
    x1 = xtime(b1);
    x2 = xtime(b2);
    x3 = xtime(b3);
    // 3b is written as xtime(b) ^ b
    m0 = x0 ^ (x1 ^ b1) ^ b2 ^ b3;
    m1 = b0 ^ x1 ^ (x2 ^ b2) ^ b3;
    m2 = b0 ^ b1 ^ x2 ^ (x3 ^ b3);
    m3 = (x0 ^ b0) ^ b1 ^ b2 ^ x3;
    mixw = {m0, m1, m2, m3};
  endfunction

  always_comb begin
    col_lsb  = {~col_q, 5'b0_0000};
    col_word = st_q[col_lsb +: 32];

    state_d  = state_q;
    col_d    = col_q;
    st_d     = st_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d = in_data;
          if (in_final) begin
            state_d = DONE;
          end else begin
            col_d   = 2'd0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        st_d[col_lsb +: 32] = mixw(col_word);
        // 2-bit counter wraps 3 -> 0 on its own
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        col_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      st_q    <= 128'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      st_q    <= st_d;
    end
  end

  // in_ready is gated by rst so nothing is accepted while reset is held.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = st_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// -----------------------------------------------------------------------------
// tb_mix_columns_iter
//
// Directed and random stimulus for mix_columns_iter. Expected states are
// pushed to exp_q at the accept handshake and popped when the DUT releases a
// result. Inputs are driven and outputs sampled 1 time unit after each rising
// clock edge.
// -----------------------------------------------------------------------------
module tb_mix_columns_iter;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_final;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int unsigned  checks;
  int unsigned  errors;
  logic [127:0] exp_q[$];

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] KC1_IN   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] KC1_OUT  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] KC2_IN   = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] KC2_OUT  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  mix_columns_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_final  (in_final),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Shift-and-add GF(2^8) multiply, reduction polynomial 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      if (aa[7]) aa = {aa[6:0], 1'b0} ^ 8'h1b;
      else       aa = {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s);
    logic [7:0]   coef [4];
    logic [127:0] r;
    logic [7:0]   acc;
    logic [7:0]   bt;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    r = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          bt  = s[127 - 32*c - 8*k -: 8];
          acc = acc ^ gmul(bt, coef[(k - row + 4) % 4]);
        end
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the presented output against the head of the scoreboard,
  // one column at a time.
  task automatic check_out(input string tag);
    logic [127:0] exp;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else                  exp = 'x;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("%s_col%0d", tag, c),
            {96'd0, out_data[127 - 32*c -: 32]}, {96'd0, exp[127 - 32*c -: 32]});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one state, wait (bounded) for in_ready, and complete the accept edge.
  task automatic send(input logic [127:0] data, input logic fin, input logic [127:0] exp);
    int n;
    in_valid = 1'b1;
    in_data  = data;
    in_final = fin;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("accept_wait", {96'd0, n < 50}, 128'd1);
    exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  // Called in the cycle right after the accept edge. Measures out_valid latency,
  // releases the result and checks the engine is ready again.
  task automatic collect(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      check({tag, "_busy_calc"}, {127'd0, busy}, 128'd1);
      tick();
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_busy_done"}, {127'd0, busy}, 128'd1);
    out_ready = 1'b1;
    check_out(tag);
    tick();
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, {127'd0, in_ready}, 128'd1);
    check({tag, "_busy_after"}, {127'd0, busy}, 128'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int sent;
    int rcvd;
    int cyc;
    logic acc_now;
    logic [127:0] r;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 128'd0;
    in_final  = 1'b0;
    out_ready = 1'b0;

    // reset values
    #1;
    check("rst_in_ready",  {127'd0, in_ready},  128'd0);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_data",  out_data,            128'd0);
    check("rst_busy",      {127'd0, busy},      128'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {127'd0, in_ready}, 128'd1);
    tick();

    // FIPS-197 round-1 vector, normal latency
    send(FIPS_IN, 1'b0, FIPS_OUT);
    collect("fips", 4);

    // known columns
    send(KC1_IN, 1'b0, KC1_OUT);
    collect("kc1", 4);
    send(KC2_IN, 1'b0, KC2_OUT);
    collect("kc2", 4);

    // bypass: unchanged, latency 1 cycle after accept
    send(FIPS_IN, 1'b1, FIPS_IN);
    collect("bypass", 0);

    // in_final toggled after accept of a normal block
    send(FIPS_IN, 1'b0, FIPS_OUT);
    in_final = 1'b1;
    tick();
    in_final = 1'b0;
    tick();
    in_final = 1'b1;
    collect("toggle", 2);
    in_final = 1'b0;

    // backpressure with a second block waiting
    send(FIPS_IN, 1'b0, FIPS_OUT);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_latency", n, 4);
    in_valid  = 1'b1;
    in_data   = KC2_IN;
    in_final  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_out_valid_%0d", i), {127'd0, out_valid}, 128'd1);
      check($sformatf("bp_out_data_%0d", i),  out_data,            FIPS_OUT);
      check($sformatf("bp_in_ready_%0d", i),  {127'd0, in_ready},  128'd0);
      tick();
    end
    exp_q.push_back(KC2_OUT);
    out_ready = 1'b1;
    check("bp_in_ready_release", {127'd0, in_ready}, 128'd0);
    check_out("bp_first");
    tick();
    out_ready = 1'b0;
    check("bp_in_ready_idle", {127'd0, in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
    collect("bp_second", 4);

    // reset two cycles after accept, in the middle of CALC
    in_valid = 1'b1;
    in_data  = FIPS_IN;
    in_final = 1'b0;
    check("mr_in_ready", {127'd0, in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mr_busy_before", {127'd0, busy}, 128'd1);
    rst = 1'b1;
    #1;
    check("mr_out_valid", {127'd0, out_valid}, 128'd0);
    check("mr_out_data",  out_data,            128'd0);
    check("mr_busy",      {127'd0, busy},      128'd0);
    check("mr_in_ready_in_rst", {127'd0, in_ready}, 128'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mr_in_ready_after", {127'd0, in_ready}, 128'd1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("mr_no_output_%0d", i), {127'd0, out_valid}, 128'd0);
      tick();
    end
    send(KC1_IN, 1'b0, KC1_OUT);
    collect("mr_after", 4);

    // back-to-back random stream with stalls on both sides
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    while ((sent < 1000 || rcvd < 1000) && cyc < 40000) begin
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_final = ($urandom_range(0, 3) == 0);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        check_out($sformatf("rand%0d", rcvd));
        rcvd++;
      end
      acc_now = 1'b0;
      if (in_valid && in_ready) begin
        r = in_final ? in_data : mix_model(in_data);
        exp_q.push_back(r);
        sent++;
        acc_now = 1'b1;
      end
      tick();
      if (acc_now) in_valid = 1'b0;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rand_sent",     sent, 1000);
    check("rand_received", rcvd, 1000);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
